// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks into a single registered write port.
// Optional macro REG_WB_FAIRNESS_EN enables the ALU starvation counter; without it, mem always wins ties.
module reg_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        wrt_sig,
  output logic [4:0]  addr_wrt,
  output logic [31:0] wrt_data,
  input  logic [4:0]  chk_addr0,
  input  logic [4:0]  chk_addr1,
  output logic        chk_hit0,
  output logic        chk_hit1,
  output logic [7:0]  drop_cnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
    $error("reg_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic        alu_win;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

`ifdef REG_WB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    alu_win = alu_valid && (!mem_valid || (starve_cnt == LIMIT));
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_ready) begin
      starve_cnt <= '0;
    end else if (alu_valid && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  always_comb begin
    alu_win = alu_valid && !mem_valid;
  end
`endif

  // Grants are forced low while reset is asserted so nothing is handed out mid-reset.
  always_comb begin
    alu_ready = rst_n && alu_win;
    mem_ready = rst_n && mem_valid && !alu_win;
    xfer      = alu_ready || mem_ready;
    sel_addr  = alu_win ? alu_addr : mem_addr;
    sel_data  = alu_win ? alu_data : mem_data;
  end

  // Single output register; a write to r0 is absorbed and only counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_sig  <= 1'b0;
      addr_wrt <= '0;
      wrt_data <= '0;
    end else begin
      wrt_sig <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        addr_wrt <= sel_addr;
        wrt_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (xfer && (sel_addr == 5'd0) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    chk_hit0 = wrt_sig && (chk_addr0 != 5'd0) && (chk_addr0 == addr_wrt);
    chk_hit1 = wrt_sig && (chk_addr1 != 5'd0) && (chk_addr1 == addr_wrt);
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: inputs change on the falling edge, outputs are sampled there too.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        wrt_sig;
  logic [4:0]  addr_wrt;
  logic [31:0] wrt_data;
  logic [4:0]  chk_addr0, chk_addr1;
  logic        chk_hit0, chk_hit1;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef REG_WB_FAIRNESS_EN
  localparam logic [5:0] ALU_WIN = 6'b001000;
`else
  localparam logic [5:0] ALU_WIN = 6'b000000;
`endif

  reg_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wrt_sig(wrt_sig), .addr_wrt(addr_wrt), .wrt_data(wrt_data),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_hit0(chk_hit0), .chk_hit1(chk_hit1),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'hAAAA;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'hBBBB;
    chk_addr0 = 5'd0; chk_addr1 = 5'd0;
    #1;
    check("rst_wrt_sig",  32'(wrt_sig), 32'd0);
    check("rst_addr_wrt", 32'(addr_wrt), 32'd0);
    check("rst_wrt_data", wrt_data, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    check("rst_edge_wrt_sig", 32'(wrt_sig), 32'd0);

    // Release reset and present an ALU-only write on the same cycle.
    rst_n = 1'b1;
    mem_valid = 1'b0;
    alu_addr = 5'd5; alu_data = 32'h1234;
    #1;
    check("alu_only_ready", 32'(alu_ready), 32'd1);
    check("alu_only_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    check("alu_wr_sig", 32'(wrt_sig), 32'd1);
    check("alu_wr_addr", 32'(addr_wrt), 32'd5);
    check("alu_wr_data", wrt_data, 32'h1234);
    #1;
    check("idle_alu_ready", 32'(alu_ready), 32'd0);
    @(negedge clk);
    check("idle_wrt_sig", 32'(wrt_sig), 32'd0);
    check("idle_addr_hold", 32'(addr_wrt), 32'd5);
    check("idle_data_hold", wrt_data, 32'h1234);

    // Contention for six cycles, both requesters holding stable payloads.
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hB2;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("tie%0d_alu_ready", i), 32'(alu_ready), 32'(ALU_WIN[i]));
      check($sformatf("tie%0d_mem_ready", i), 32'(mem_ready), 32'(!ALU_WIN[i]));
      @(negedge clk);
      check($sformatf("tie%0d_wrt_sig", i), 32'(wrt_sig), 32'd1);
      check($sformatf("tie%0d_addr", i), 32'(addr_wrt), ALU_WIN[i] ? 32'd1 : 32'd2);
      check($sformatf("tie%0d_data", i), wrt_data, ALU_WIN[i] ? 32'hA1 : 32'hB2);
    end

    // Loads to r0 are absorbed and counted; the counter saturates.
    alu_valid = 1'b0;
    mem_addr = 5'd0; mem_data = 32'hFFFF;
    #1;
    check("r0_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    check("r0_wrt_sig", 32'(wrt_sig), 32'd0);
    check("r0_drop_cnt_1", 32'(drop_cnt), 32'd1);
    check("r0_addr_loaded", 32'(addr_wrt), 32'd0);
    check("r0_data_loaded", wrt_data, 32'hFFFF);
    check("r0_zero_chk_no_hit", 32'(chk_hit0), 32'd0);
    repeat (299) @(negedge clk);
    check("r0_drop_cnt_sat", 32'(drop_cnt), 32'd255);
    check("r0_sat_wrt_sig", 32'(wrt_sig), 32'd0);

    // In-flight hazard check.
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    chk_addr0 = 5'd7; chk_addr1 = 5'd8;
    #1;
    check("hit_pre_hit0", 32'(chk_hit0), 32'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    check("hit_hit0", 32'(chk_hit0), 32'd1);
    check("hit_hit1", 32'(chk_hit1), 32'd0);
    @(negedge clk);
    check("hit_after_hit0", 32'(chk_hit0), 32'd0);
    check("hit_after_hit1", 32'(chk_hit1), 32'd0);
    check("hit_drop_cnt_held", 32'(drop_cnt), 32'd255);

    // Reset mid-cycle discards the staged write.
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
    check("mid_staged_wrt_sig", 32'(wrt_sig), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wrt_sig", 32'(wrt_sig), 32'd0);
    check("mid_rst_addr", 32'(addr_wrt), 32'd0);
    check("mid_rst_data", wrt_data, 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b0;
    #1;
    check("post_rst_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    check("post_rst_wrt_sig", 32'(wrt_sig), 32'd1);
    check("post_rst_addr", 32'(addr_wrt), 32'd3);
    check("post_rst_data", wrt_data, 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
